// File: rtl/bytecode_loader_pkg.sv
// rtl/bytecode_loader_pkg.sv - shared states and constants for the bytecode loader
package bytecode_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WRITE,
        ST_DONE,
        ST_ERROR
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int BYTE_WIDTH = 8;

    // JVM nop, used to pad the unfilled tail of the final word
    localparam logic [BYTE_WIDTH-1:0] NOP_PAD = 8'h00;

endpackage

// File: rtl/bytecode_loader_byte_packer.sv
// rtl/bytecode_loader_byte_packer.sv - big-endian byte-to-word packing buffer
module byte_packer
    import bytecode_loader_pkg::*;
(
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             i_clear,
    input  logic                             i_insert,
    input  logic [BYTE_WIDTH-1:0]            i_byte,
    output logic [WORD_BYTES*BYTE_WIDTH-1:0] o_word,
    output logic                             o_full
);

    logic [1:0]                      r_count;
    logic [WORD_BYTES*BYTE_WIDTH-1:0] r_word;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_word  <= '0;
        end else if (i_clear) begin
            r_count <= '0;
            r_word  <= {WORD_BYTES{NOP_PAD}};
        end else if (i_insert) begin
            r_count <= r_count + 2'd1;
            case (r_count)
                2'd0:    r_word[31:24] <= i_byte;
                2'd1:    r_word[23:16] <= i_byte;
                2'd2:    r_word[15:8]  <= i_byte;
                default: r_word[7:0]   <= i_byte;
            endcase
        end
    end

    assign o_word = r_word;
    // High in the same cycle as the insert that completes the word
    assign o_full = i_insert && (r_count == 2'(WORD_BYTES - 1));

endmodule

// File: rtl/bytecode_loader.sv
// rtl/bytecode_loader.sv - packs a bytecode byte stream into words and writes instruction RAM
module bytecode_loader
    import bytecode_loader_pkg::*;
#(
    parameter int RAM_SIZE      = 256,
    parameter int ADDRESS_WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [ADDRESS_WIDTH-1:0] base_address,
    input  logic                     load_start,
    input  logic [7:0]               byte_in,
    input  logic                     byte_valid,
    input  logic                     byte_last,
    output logic                     byte_ready,
    output logic [ADDRESS_WIDTH-1:0] mem_address,
    output logic [31:0]              mem_data,
    output logic                     mem_rwn,
    output logic                     mem_start,
    input  logic                     mem_ready,
    output logic                     done,
    output logic                     overflow
);

    localparam logic [ADDRESS_WIDTH:0] RAM_LIMIT = (ADDRESS_WIDTH + 1)'(RAM_SIZE);

    state_t                   r_state;
    state_t                   w_next;
    logic [ADDRESS_WIDTH-1:0] r_addr;
    logic                     r_last;
    logic                     r_byte_ready;
    logic                     r_mem_start;
    logic                     r_mem_rwn;
    logic                     r_done;
    logic                     r_overflow;

    logic                     w_clear;
    logic                     w_insert;
    logic                     w_load_base;
    logic                     w_advance;
    logic                     w_full;
    logic                     w_accept;
    logic                     w_mem_accept;
    logic [31:0]              w_word;
    logic [ADDRESS_WIDTH:0]   w_addr_next_wide;

    assign w_accept         = r_byte_ready && byte_valid;
    assign w_mem_accept     = r_mem_start && mem_ready;
    // One bit wider than the address so a wrap to zero still reads as out of room
    assign w_addr_next_wide = {1'b0, r_addr} + (ADDRESS_WIDTH + 1)'(WORD_BYTES);

    byte_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .i_clear  (w_clear),
        .i_insert (w_insert),
        .i_byte   (byte_in),
        .o_word   (w_word),
        .o_full   (w_full)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        w_clear     = 1'b0;
        w_insert    = 1'b0;
        w_load_base = 1'b0;
        w_advance   = 1'b0;
        case (r_state)
            ST_IDLE, ST_DONE, ST_ERROR: begin
                if (load_start) begin
                    w_next      = ST_COLLECT;
                    w_clear     = 1'b1;
                    w_load_base = 1'b1;
                end
            end
            ST_COLLECT: begin
                if (w_accept) begin
                    w_insert = 1'b1;
                    if (w_full || byte_last) begin
                        w_next = ST_WRITE;
                    end
                end
            end
            ST_WRITE: begin
                if (w_mem_accept) begin
                    if (r_last) begin
                        w_next = ST_DONE;
                    end else if (w_addr_next_wide >= RAM_LIMIT) begin
                        w_next = ST_ERROR;
                    end else begin
                        w_next    = ST_COLLECT;
                        w_clear   = 1'b1;
                        w_advance = 1'b1;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr <= '0;
            r_last <= 1'b0;
        end else begin
            if (w_load_base) begin
                r_addr <= base_address;
            end else if (w_advance) begin
                r_addr <= r_addr + ADDRESS_WIDTH'(WORD_BYTES);
            end
            if (w_clear) begin
                r_last <= 1'b0;
            end else if (w_insert) begin
                r_last <= byte_last;
            end
        end
    end

    // Outputs are decoded from the next state so they are registered yet aligned with the state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_byte_ready <= 1'b0;
            r_mem_start  <= 1'b0;
            r_mem_rwn    <= 1'b1;
            r_done       <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_byte_ready <= (w_next == ST_COLLECT);
            r_mem_start  <= (w_next == ST_WRITE);
            r_mem_rwn    <= (w_next != ST_WRITE);
            r_done       <= (w_next == ST_DONE);
            r_overflow   <= (w_next == ST_ERROR);
        end
    end

    assign byte_ready  = r_byte_ready;
    assign mem_start   = r_mem_start;
    assign mem_rwn     = r_mem_rwn;
    assign done        = r_done;
    assign overflow    = r_overflow;
    assign mem_address = r_addr;
    assign mem_data    = w_word;

endmodule

// File: tb/tb_bytecode_loader.sv
// tb/tb_bytecode_loader.sv - scoreboard bench for bytecode_loader at two RAM sizes
module tb_bytecode_loader;

    typedef struct {
        bit               use8;
        logic [7:0]       base;
        int               nbytes;
        logic [0:15][7:0] b;
        bit               last_flag;
        int               mem_wait;
        int               gap;
        bit               exp_done;
        bit               exp_ovf;
    } vec_t;

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] base_address;
    logic       load_start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       mem_ready;
    bit         use8;

    logic       a_byte_ready, a_mem_rwn, a_mem_start, a_done, a_overflow;
    logic [7:0] a_mem_address;
    logic [31:0] a_mem_data;
    logic       b_byte_ready, b_mem_rwn, b_mem_start, b_done, b_overflow;
    logic [7:0] b_mem_address;
    logic [31:0] b_mem_data;
    logic       a_load, b_load;

    logic       s_byte_ready, s_mem_rwn, s_mem_start, s_done, s_overflow;
    logic [7:0] s_mem_address;
    logic [31:0] s_mem_data;

    int  checks = 0;
    int  passes = 0;
    int  mem_wait = 0;
    wr_t exp_q[$];
    vec_t vecs[7];

    always #5 clk = ~clk;

    assign a_load = load_start && !use8;
    assign b_load = load_start && use8;
    assign s_byte_ready  = use8 ? b_byte_ready  : a_byte_ready;
    assign s_mem_rwn     = use8 ? b_mem_rwn     : a_mem_rwn;
    assign s_mem_start   = use8 ? b_mem_start   : a_mem_start;
    assign s_done        = use8 ? b_done        : a_done;
    assign s_overflow    = use8 ? b_overflow    : a_overflow;
    assign s_mem_address = use8 ? b_mem_address : a_mem_address;
    assign s_mem_data    = use8 ? b_mem_data    : a_mem_data;

    bytecode_loader #(.RAM_SIZE(256), .ADDRESS_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .base_address(base_address), .load_start(a_load),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(a_byte_ready), .mem_address(a_mem_address), .mem_data(a_mem_data),
        .mem_rwn(a_mem_rwn), .mem_start(a_mem_start), .mem_ready(mem_ready),
        .done(a_done), .overflow(a_overflow)
    );

    bytecode_loader #(.RAM_SIZE(8), .ADDRESS_WIDTH(8)) dut8 (
        .clk(clk), .reset(reset), .base_address(base_address), .load_start(b_load),
        .byte_in(byte_in), .byte_valid(byte_valid), .byte_last(byte_last),
        .byte_ready(b_byte_ready), .mem_address(b_mem_address), .mem_data(b_mem_data),
        .mem_rwn(b_mem_rwn), .mem_start(b_mem_start), .mem_ready(mem_ready),
        .done(b_done), .overflow(b_overflow)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // Memory model: optional wait states, hold checks, scoreboard pop on each accepted write
    initial begin : mem_side
        int         wait_cnt;
        bit         holding;
        logic [7:0] held_addr;
        logic [31:0] held_data;
        wr_t        e;
        wait_cnt = 0;
        holding  = 0;
        mem_ready = 1'b1;
        forever begin
            @(negedge clk);
            if (s_mem_start) begin
                if (holding) begin
                    check("hold_addr", {24'h0, s_mem_address}, {24'h0, held_addr});
                    check("hold_data", s_mem_data, held_data);
                    check("hold_byte_ready", {31'h0, s_byte_ready}, 32'h0);
                end
                held_addr = s_mem_address;
                held_data = s_mem_data;
                holding   = 1;
                if (wait_cnt < mem_wait) begin
                    mem_ready = 1'b0;
                    wait_cnt++;
                end else begin
                    mem_ready = 1'b1;
                    holding   = 0;
                    if (exp_q.size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_write: got write %h at %h, required none",
                                 s_mem_data, s_mem_address);
                    end else begin
                        e = exp_q.pop_front();
                        check("wr_addr", {24'h0, s_mem_address}, {24'h0, e.addr});
                        check("wr_data", s_mem_data, e.data);
                        check("wr_rwn", {31'h0, s_mem_rwn}, 32'h0);
                    end
                end
            end else begin
                holding   = 0;
                wait_cnt  = 0;
                mem_ready = 1'b1;
            end
        end
    end

    task automatic load(input logic [7:0] base);
        @(negedge clk);
        base_address = base;
        load_start   = 1'b1;
        @(negedge clk);
        load_start   = 1'b0;
        check("ready_after_load", {31'h0, s_byte_ready}, 32'h1);
        check("done_cleared", {31'h0, s_done}, 32'h0);
        check("ovf_cleared", {31'h0, s_overflow}, 32'h0);
    endtask

    // Entered and left at a negedge; returns after the accepting edge
    task automatic send_byte(input logic [7:0] b, input bit last, output bit aborted);
        int t;
        byte_in    = b;
        byte_valid = 1'b1;
        byte_last  = last;
        aborted    = 0;
        t          = 0;
        while (!s_byte_ready) begin
            if (s_done || s_overflow) begin
                aborted = 1;
                break;
            end
            @(negedge clk);
            t++;
            if (t > 200) begin
                checks++;
                $display("FAIL byte_timeout: got no byte_ready in %0d cycles, required one", t);
                aborted = 1;
                break;
            end
        end
        if (!aborted) @(negedge clk);
        byte_valid = 1'b0;
        byte_last  = 1'b0;
    endtask

    task automatic wait_end();
        int t;
        t = 0;
        while (!(s_done || s_overflow) && t < 300) begin
            @(negedge clk);
            t++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int          ram, addr, i, k;
        bit          lastw, ab;
        logic [31:0] word;
        use8     = v.use8;
        mem_wait = v.mem_wait;
        exp_q.delete();
        ram  = v.use8 ? 8 : 256;
        addr = int'(v.base);
        i    = 0;
        while (i < v.nbytes) begin
            word  = 32'h0;
            k     = 0;
            lastw = 0;
            while (k < 4 && i < v.nbytes) begin
                word[31-8*k -: 8] = v.b[i];
                lastw = v.last_flag && (i == v.nbytes - 1);
                i++;
                k++;
                if (lastw) break;
            end
            exp_q.push_back('{addr: 8'(addr), data: word});
            if (lastw) break;
            if (addr + 4 >= ram) break;
            addr += 4;
        end
        load(v.base);
        for (int j = 0; j < v.nbytes; j++) begin
            send_byte(v.b[j], v.last_flag && (j == v.nbytes - 1), ab);
            if (ab) break;
            repeat (v.gap) @(negedge clk);
        end
        wait_end();
        $display("vector %0d finished", idx);
        check("end_done", {31'h0, s_done}, {31'h0, v.exp_done});
        check("end_ovf", {31'h0, s_overflow}, {31'h0, v.exp_ovf});
        check("end_byte_ready", {31'h0, s_byte_ready}, 32'h0);
        repeat (3) @(negedge clk);
        check("writes_remaining", exp_q.size(), 32'h0);
        check("end_mem_start", {31'h0, s_mem_start}, 32'h0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_byte_ready"}, {31'h0, s_byte_ready}, 32'h0);
        check({tag, "_mem_start"}, {31'h0, s_mem_start}, 32'h0);
        check({tag, "_mem_rwn"}, {31'h0, s_mem_rwn}, 32'h1);
        check({tag, "_done"}, {31'h0, s_done}, 32'h0);
        check({tag, "_ovf"}, {31'h0, s_overflow}, 32'h0);
        check({tag, "_addr"}, {24'h0, s_mem_address}, 32'h0);
        check({tag, "_data"}, s_mem_data, 32'h0);
    endtask

    initial begin : main
        bit ab;
        vecs[0] = '{1'b0, 8'h00, 5, {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, {11{8'h00}}}, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[1] = '{1'b0, 8'h00, 5, {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, {11{8'h00}}}, 1'b1, 3, 0, 1'b1, 1'b0};
        vecs[2] = '{1'b1, 8'h00, 9, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'h09, {7{8'h00}}}, 1'b1, 0, 0, 1'b0, 1'b1};
        vecs[3] = '{1'b1, 8'h00, 8, {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, {8{8'h00}}}, 1'b1, 0, 0, 1'b1, 1'b0};
        vecs[4] = '{1'b0, 8'h10, 1, {8'hB1, {15{8'h00}}}, 1'b1, 0, 2, 1'b1, 1'b0};
        vecs[5] = '{1'b0, 8'hF8, 6, {8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hA5, 8'hA6, {10{8'h00}}}, 1'b1, 1, 1, 1'b1, 1'b0};
        vecs[6] = '{1'b0, 8'hF8, 9, {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hC5, 8'hC6, 8'hC7, 8'hC8, 8'hC9, {7{8'h00}}}, 1'b1, 0, 0, 1'b0, 1'b1};

        reset        = 1'b0;
        base_address = 8'h00;
        load_start   = 1'b0;
        byte_in      = 8'h00;
        byte_valid   = 1'b0;
        byte_last    = 1'b0;
        use8         = 0;
        repeat (2) @(negedge clk);
        check_reset_values("rst");
        reset = 1'b1;
        repeat (2) @(negedge clk);
        check_reset_values("post_rst");

        for (int n = 0; n < 7; n++) run_vec(vecs[n], n);

        // Cycle-exact timing: word boundary turnaround and done latency
        use8     = 0;
        mem_wait = 0;
        exp_q.delete();
        exp_q.push_back('{addr: 8'h20, data: 32'hDEADBEEF});
        exp_q.push_back('{addr: 8'h24, data: 32'hAA000000});
        load(8'h20);
        send_byte(8'hDE, 0, ab);
        send_byte(8'hAD, 0, ab);
        send_byte(8'hBE, 0, ab);
        send_byte(8'hEF, 0, ab);
        check("t_mem_start_after_4th", {31'h0, s_mem_start}, 32'h1);
        check("t_ready_low_in_write", {31'h0, s_byte_ready}, 32'h0);
        @(negedge clk);
        check("t_ready_back", {31'h0, s_byte_ready}, 32'h1);
        check("t_mem_start_drop", {31'h0, s_mem_start}, 32'h0);
        send_byte(8'hAA, 1, ab);
        check("t_last_write", {31'h0, s_mem_start}, 32'h1);
        check("t_done_not_yet", {31'h0, s_done}, 32'h0);
        @(negedge clk);
        check("t_done_next", {31'h0, s_done}, 32'h1);
        repeat (2) @(negedge clk);
        check("t_writes_remaining", exp_q.size(), 32'h0);

        // Reset while a write is pending
        mem_wait = 50;
        exp_q.delete();
        load(8'h40);
        send_byte(8'h11, 1, ab);
        repeat (2) @(negedge clk);
        check("r_in_write", {31'h0, s_mem_start}, 32'h1);
        reset = 1'b0;
        #1;
        check_reset_values("mid_rst");
        @(negedge clk);
        reset    = 1'b1;
        mem_wait = 0;
        repeat (2) @(negedge clk);
        check_reset_values("after_rst");
        run_vec(vecs[0], 7);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
